// File: rtl/core_inst_seq.sv
`default_nettype none
// =============================================================================
// Module  : core_inst_seq
// Brief   : Attention-pass sequencer driving core.inst / core.mem_in
//           (QLOAD, KLOAD, KPRE, EXEC, DRAIN, ACC, DIV, FIN).
//           Macro READBACK_EN adds a pmem readback phase (RDBK) and rd_valid.
// Rev     : 1.0
// =============================================================================
module core_inst_seq #(
    parameter int col       = 8,
    parameter int bw        = 8,
    parameter int pr        = 8,
    parameter int N_Q       = 8,
    parameter int DRAIN_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [pr*bw-1:0]   din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [19:0]        inst,
    output logic [pr*bw-1:0]   mem_in,
    output logic               busy,
`ifdef READBACK_EN
    output logic               done,
    output logic               rd_valid
`else
    output logic               done
`endif
);

    localparam int c_b_sfp_wr  = 19;
    localparam int c_b_acc     = 18;
    localparam int c_b_div     = 17;
    localparam int c_b_ofifo   = 16;
    localparam int c_b_exec    = 7;
    localparam int c_b_kload   = 6;
    localparam int c_b_q_rd    = 5;
    localparam int c_b_q_wr    = 4;
    localparam int c_b_k_rd    = 3;
    localparam int c_b_k_wr    = 2;
    localparam int c_b_p_rd    = 1;
    localparam int c_b_p_wr    = 0;

    localparam int         c_dw         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [3:0] c_nq_last    = 4'(N_Q - 1);
    localparam logic [3:0] c_col_last   = 4'(col - 1);
    localparam logic [c_dw-1:0] c_drain_last = c_dw'(DRAIN_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_QLOAD = 4'd1,
        S_KLOAD = 4'd2,
        S_KPRE  = 4'd3,
        S_EXEC  = 4'd4,
        S_DRAIN = 4'd5,
        S_ACC   = 4'd6,
        S_DIV   = 4'd7,
        S_RDBK  = 4'd8,
        S_FIN   = 4'd9
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        i_q, i_d;
    // tail marks the extra trailing cycle of KPRE/EXEC so i never needs a 5th bit
    logic              tail_q, tail_d;
    logic [c_dw-1:0]   drain_q, drain_d;
    logic [19:0]       inst_q, inst_d;
    logic [pr*bw-1:0]  mem_in_q, mem_in_d;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        tail_d    = tail_q;
        drain_d   = drain_q;
        inst_d    = '0;
        mem_in_d  = mem_in_q;
        din_ready = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_QLOAD;
                    i_d     = '0;
                    tail_d  = 1'b0;
                end
            end
            S_QLOAD: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    inst_d[c_b_q_wr] = 1'b1;
                    inst_d[15:12]    = i_q;
                    mem_in_d         = din;
                    if (i_q == c_nq_last) begin
                        state_d = S_KLOAD;
                        i_d     = '0;
                    end else begin
                        i_d = i_q + 4'd1;
                    end
                end
            end
            S_KLOAD: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    inst_d[c_b_k_wr] = 1'b1;
                    inst_d[15:12]    = i_q;
                    mem_in_d         = din;
                    if (i_q == c_col_last) begin
                        state_d = S_KPRE;
                        i_d     = '0;
                        tail_d  = 1'b0;
                    end else begin
                        i_d = i_q + 4'd1;
                    end
                end
            end
            S_KPRE: begin
                inst_d[c_b_kload] = 1'b1;
                if (!tail_q) begin
                    inst_d[c_b_k_rd] = 1'b1;
                    inst_d[15:12]    = i_q;
                    if (i_q == c_col_last) begin
                        tail_d = 1'b1;
                    end else begin
                        i_d = i_q + 4'd1;
                    end
                end else begin
                    state_d = S_EXEC;
                    i_d     = '0;
                    tail_d  = 1'b0;
                end
            end
            S_EXEC: begin
                inst_d[c_b_exec] = 1'b1;
                if (!tail_q) begin
                    inst_d[c_b_q_rd] = 1'b1;
                    inst_d[15:12]    = i_q;
                    if (i_q == c_nq_last) begin
                        tail_d = 1'b1;
                    end else begin
                        i_d = i_q + 4'd1;
                    end
                end else begin
                    state_d = S_DRAIN;
                    i_d     = '0;
                    tail_d  = 1'b0;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == c_drain_last) begin
                    state_d = S_ACC;
                    i_d     = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_ACC: begin
                inst_d[c_b_ofifo] = 1'b1;
                inst_d[c_b_acc]   = 1'b1;
                if (i_q == c_nq_last) begin
                    state_d = S_DIV;
                    i_d     = '0;
                end else begin
                    i_d = i_q + 4'd1;
                end
            end
            S_DIV: begin
                inst_d[c_b_div]    = 1'b1;
                inst_d[c_b_p_wr]   = 1'b1;
                inst_d[c_b_sfp_wr] = 1'b1;
                inst_d[11:8]       = i_q;
                if (i_q == c_nq_last) begin
`ifdef READBACK_EN
                    state_d = S_RDBK;
`else
                    state_d = S_FIN;
`endif
                    i_d = '0;
                end else begin
                    i_d = i_q + 4'd1;
                end
            end
`ifdef READBACK_EN
            S_RDBK: begin
                inst_d[c_b_p_rd] = 1'b1;
                inst_d[11:8]     = i_q;
                if (i_q == c_nq_last) begin
                    state_d = S_FIN;
                    i_d     = '0;
                end else begin
                    i_d = i_q + 4'd1;
                end
            end
`endif
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            tail_q   <= 1'b0;
            drain_q  <= '0;
            inst_q   <= '0;
            mem_in_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            tail_q   <= tail_d;
            drain_q  <= drain_d;
            inst_q   <= inst_d;
            mem_in_q <= mem_in_d;
        end
    end

    assign inst   = inst_q;
    assign mem_in = mem_in_q;

`ifdef READBACK_EN
    // pmem data lands on core.out one cycle after the p_rd strobe is presented
    logic rd_valid_q, rd_valid_d;

    always_comb begin
        rd_valid_d = inst_q[c_b_p_rd];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;
`endif

endmodule
`default_nettype wire
